// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_ITER = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic mdu_is_multi(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shift-add multiply or restoring shift-subtract divide.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: upper half accumulates, lower half holds the multiplier shifting out.
  // Divide: upper half is the partial remainder, lower half the dividend/quotient.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = '0;
    if (!div_mode) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  mdu_state_e state, state_next;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_mode;
  logic               neg_q;
  logic               neg_r;
  logic               zero_div;
  logic               done_q, dbz_q;

  logic               accept;
  logic               last_iter;
  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   hi_res, lo_res;

  assign accept    = (state == MDU_IDLE) && start && !flush;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign op_signed = mdu_is_signed(op);
  assign op_div    = mdu_is_div(op);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  mdu_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode (div_mode),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (accept && mdu_is_multi(op)) state_next = MDU_ITER;
      MDU_ITER: begin
        if (flush) begin
          state_next = MDU_IDLE;
        end else if (last_iter) begin
          state_next = MDU_FIX;
        end
      end
      MDU_FIX:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // Sign correction of the magnitude result; divide-by-zero overrides everything.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    if (neg_q) quo = -quo;
    if (neg_r) rem = -rem;
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (zero_div) begin
      hi_res = a_raw;
      lo_res = '1;
    end else if (div_mode) begin
      hi_res = rem;
      lo_res = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            if (op == MDU_MTHI) begin
              hi_q <= a;
            end else if (op == MDU_MTLO) begin
              lo_q <= a;
            end else if (mdu_is_multi(op)) begin
              cnt      <= '0;
              div_mode <= op_div;
              opnd     <= op_div ? b_mag : a_mag;
              acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r    <= op_signed && a[WIDTH-1];
              zero_div <= op_div && (b == '0);
              a_raw    <= a;
            end
          end
        end
        MDU_ITER: begin
          if (!flush) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
          end
        end
        MDU_FIX: begin
          if (!flush) begin
            hi_q   <= hi_res;
            lo_q   <= lo_res;
            done_q <= 1'b1;
            dbz_q  <= zero_div;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != MDU_IDLE);
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences, random ops vs model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [2:0] o, input logic [31:0] av);
    start = 1'b1; op = o; a = av;
    step();
    start = 1'b0;
  endtask

  // Issue a multi-cycle op and check latency, busy profile and result at done.
  task automatic run_mc(input string nm, input logic [2:0] o, input logic [31:0] av, bv,
                        input logic [31:0] eh, el, input logic ed);
    int   n;
    logic busy_ok;
    start = 1'b1; op = o; a = av; b = bv;
    step();
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < int'(W) + 10) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'(W + 1));
    check({nm, " busy"}, 64'(busy_ok), 64'd1);
    check({nm, " busy at done"}, 64'(busy), 64'd0);
    check({nm, " hi/lo"}, {hi, lo}, {eh, el});
    check({nm, " dbz"}, 64'(dbz), 64'(ed));
  endtask

  // Architectural reference: plain integer arithmetic on the ISA definitions.
  task automatic model(input logic [2:0] o, input logic [31:0] av, bv,
                       inout logic [31:0] mh, ml, output logic md);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0]        up;
    sa = 64'($signed(av));
    sb = 64'($signed(bv));
    md = 1'b0;
    case (o)
      3'd0: begin sp = sa * sb; mh = sp[63:32]; ml = sp[31:0]; end
      3'd1: begin up = {32'd0, av} * {32'd0, bv}; mh = up[63:32]; ml = up[31:0]; end
      3'd2, 3'd3: begin
        if (bv == 32'd0) begin
          mh = av; ml = 32'hFFFF_FFFF; md = 1'b1;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          ml = sq[31:0]; mh = sr[31:0];
        end else begin
          ml = av / bv; mh = av % bv;
        end
      end
      3'd4: mh = av;
      3'd5: ml = av;
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mh, ml, ra, rb;
    logic        md, seen;
    logic [2:0]  ro;
    int unsigned sel;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) step();
    rst = 1'b0;
    check("reset flags", {61'd0, busy, done, dbz}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);

    vecs[0] = '{"mult neg*7",   MDU_MULT,  32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[1] = '{"multu big*7",  MDU_MULTU, 32'hFFFF_FFFF, 32'd7,         32'h0000_0006, 32'hFFFF_FFF9, 1'b0};
    vecs[2] = '{"div -7/2",     MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{"divu 100/7",   MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{"divu by zero", MDU_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{"div overflow", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6] = '{"div by zero",  MDU_DIV,   32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{"mult minsq",   MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    vecs[8] = '{"div 7/-2",     MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{"multu 0*x",    MDU_MULTU, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0};

    for (int i = 0; i < 10; i++) begin
      run_mc(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
      step();
      check({vecs[i].name, " pulse end"}, {62'd0, done, dbz}, 64'd0);
    end

    // MTHI in idle, then an MTLO issued mid-multiply must be ignored.
    single(MDU_MTHI, 32'hDEAD_BEEF);
    check("mthi hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi busy/done", {62'd0, busy, done}, 64'd0);
    start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd5;
    step();
    start = 1'b0;
    repeat (10) step();
    single(MDU_MTLO, 32'd1);
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 60) begin step(); n++; end
      check("mid-op mtlo done seen", 64'(done), 64'd1);
    end
    check("mid-op mtlo hi/lo", {hi, lo}, {32'd0, 32'd15});

    // Flush during ITER keeps preloaded HI/LO and never pulses done.
    single(MDU_MTHI, 32'hAAAA_0000);
    single(MDU_MTLO, 32'h0000_5555);
    start = 1'b1; op = MDU_MULTU; a = 32'h1234; b = 32'h5678;
    step();
    start = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush iter busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin if (done === 1'b1) seen = 1'b1; step(); end
    check("flush iter no done", 64'(seen), 64'd0);
    check("flush iter hi/lo", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});

    // Flush during the final correction cycle.
    start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0;
    repeat (W) step();
    check("fix busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush fix done/busy", {62'd0, busy, done}, 64'd0);
    check("flush fix hi/lo", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});

    // Flush in idle drops a simultaneous start.
    flush = 1'b1;
    single(MDU_MTHI, 32'h0BAD_0BAD);
    check("idle flush mthi", 64'(hi), 64'hAAAA_0000);
    single(MDU_MULT, 32'd9);
    flush = 1'b0;
    check("idle flush mult busy", 64'(busy), 64'd0);

    // Reserved op codes do nothing.
    single(3'd6, 32'h1111_1111);
    single(3'd7, 32'h2222_2222);
    check("reserved busy", 64'(busy), 64'd0);
    check("reserved hi/lo", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});

    // Reset in the middle of a divide.
    start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midop rst flags", {61'd0, busy, done, dbz}, 64'd0);
    check("midop rst hi/lo", {hi, lo}, 64'd0);
    run_mc("post-rst multu 2*3", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    // Random back-to-back traffic against the model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    mh = '0;
    ml = '0;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 15);
      ro  = (sel < 12) ? 3'(sel % 4) : 3'(sel - 8);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      model(ro, ra, rb, mh, ml, md);
      if (mdu_is_multi(ro)) begin
        run_mc("random mc", ro, ra, rb, mh, ml, md);
      end else begin
        single(ro, ra);
        check("random single busy/done", {62'd0, busy, done}, 64'd0);
        check("random single hi/lo", {hi, lo}, {mh, ml});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit owning the architectural HI/LO registers, sitting in the execute stage beside the ALU. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes. It exposes HI/LO continuously for MFHI/MFLO and drives `busy` so the pipeline control can stall.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; legal values are ≥ 2.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 3: operation code (see package).
- `a` input WIDTH: rs operand (dividend / multiplicand / MT source).
- `b` input WIDTH: rt operand (divisor / multiplier).
- `flush` input 1: cancel the in-flight operation (exception/branch squash).
- `busy` output 1: multi-cycle operation in flight.
- `done` output 1: one-cycle pulse, HI/LO just updated by a multi-cycle op.
- `dbz` output 1: divide-by-zero flag, valid with `done`.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- Op codes:
  - 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO.
  - 6–7 are reserved: accepted with no effect.
- FSM states: IDLE, ITER, FIX.
- IDLE, `start`=1:
  - MTHI/MTLO: write `a` into HI/LO at that edge. Stay in IDLE; `busy` stays 0.
  - MULT*/DIV*: latch the operation and operands, clear the iteration counter, go to ITER.
  - Signed ops latch |a| and |b| and record the result sign(s). Unsigned ops latch the raw operands.
- ITER: one iteration per cycle for WIDTH cycles.
  - Multiply: shift-add, 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, WIDTH-bit quotient and remainder.
  - When the counter reaches WIDTH−1, go to FIX.
- FIX: one cycle, then return to IDLE.
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Write HI = upper/remainder and LO = lower/quotient. Pulse `done`.
- Divide by zero, signed or unsigned: HI = `a`, LO = all ones, `dbz`=1 with `done`. Latency is unchanged.
- Signed overflow (−2^(WIDTH−1) / −1): LO = 0x80…0, HI = 0. No flag.
- `start` while `busy`=1 is ignored, including MT ops; the control must stall.
- `flush`=1 in ITER or FIX: go to IDLE at that edge. HI/LO are unchanged and `done` is not pulsed.
- `flush` in IDLE has priority over `start`: the start is dropped.
- `rst` has priority over everything.

## Timing
- Reset values: HI=0, LO=0, `busy`=0, `done`=0, `dbz`=0, state = IDLE.
- `rst` asserted mid-operation aborts the operation and applies the reset values.
- Multi-cycle op accepted at edge N:
  - `busy`=1 in the cycles after edges N … N+WIDTH (WIDTH+1 cycles).
  - HI/LO update at edge N+WIDTH+1.
  - In the cycle after that edge, `busy`=0 and `done`=1 (and `dbz` if applicable).
  - A new `start` is accepted at edge N+WIDTH+1 at the earliest. That is the same edge where `done` rises, because `busy` is already 0 during the preceding cycle? No: `busy` is 1 during that cycle, so the earliest new acceptance is edge N+WIDTH+2.
- MTHI/MTLO accepted at edge N: register updated at edge N; no `done`.
- `hi`/`lo` are register outputs with no combinational path from the inputs.
- MFHI/MFLO read them directly while `busy`=0.

## Structure
- Shared package `mdu_pkg`:
  - op code constants (`MDU_MULT` … `MDU_MTLO`),
  - FSM state enum (`MDU_IDLE`, `MDU_ITER`, `MDU_FIX`),
  - helper `mdu_is_signed(op)`.
- The decoder that produces `op`/`start` from the instruction imports `mdu_pkg`.
- One natural sub-module is `mdu_iter_step`. It is combinational and produces the next accumulator/quotient/remainder for a single step, selected by a mul/div mode bit.
- Counter width is $clog2(WIDTH)+1.

## Test plan
- MULT a=0xFFFFFFFF, b=7: HI=0xFFFFFFFF, LO=0xFFFFFFF9; `done` in the cycle after edge N+33. MULTU with the same operands: HI=0x00000006, LO=0xFFFFFFF9.
- DIV a=0xFFFFFFF9 (−7), b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7: LO=14, HI=2.
- DIVU a=0x12345678, b=0: HI=0x12345678, LO=0xFFFFFFFF, `dbz`=1 for one cycle. DIV a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0, `dbz`=0.
- MTHI a=0xDEADBEEF in IDLE: HI=0xDEADBEEF the next cycle with `busy` never high. Then MULTU 3×5, plus a MTLO of 0x1 at mid-op: the MTLO is ignored and LO=15.
- Preload HI=0xAAAA0000, LO=0x5555. Start MULTU, assert `flush` at iteration 10: `busy`=0 the next cycle, no `done`, HI/LO hold their preloaded values.
- `rst` asserted at iteration 5 of DIV: all outputs return to zero the next cycle. A subsequent MULTU 2×3 gives LO=6, HI=0.
